// File: rtl/pc_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pc_hazard_ctrl_pkg : shared types for the PC / pipeline hazard controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pc_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_MEM_WAIT   = 2'd1,
    ST_HOLD_REDIR = 2'd2
  } state_e;

  // Lower encoding = higher priority; NONE is never a winner.
  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_TRAP   = 2'd1,
    CAUSE_BRANCH = 2'd2,
    CAUSE_JUMP   = 2'd3
  } cause_e;

  localparam logic [31:0] c_nop_insn = 32'h0000_0013;

`ifdef HAZARD_PERF_EN
  localparam bit c_perf_en = 1'b1;
`else
  localparam bit c_perf_en = 1'b0;
`endif

  function automatic cause_e redirect_cause(input logic trap, input logic br, input logic jmp);
    if (trap)     return CAUSE_TRAP;
    else if (br)  return CAUSE_BRANCH;
    else if (jmp) return CAUSE_JUMP;
    else          return CAUSE_NONE;
  endfunction

  function automatic logic cause_wins(input cause_e nw, input cause_e old);
    return (nw != CAUSE_NONE) && ((old == CAUSE_NONE) || (nw <= old));
  endfunction

  // {if_id_flush, id_ex_flush}: a jump is decoded in ID, so ID/EX is still valid.
  function automatic logic [1:0] cause_flushes(input cause_e c);
    case (c)
      CAUSE_TRAP, CAUSE_BRANCH: return 2'b11;
      CAUSE_JUMP:               return 2'b10;
      default:                  return 2'b00;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_hazard_ctrl_hazard_detect.sv
// ---------------------------------------------------------------------------
// pc_hazard_ctrl_hazard_detect : load-use comparator between ID sources and EX load
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pc_hazard_ctrl_hazard_detect #(
  parameter int RF_AW = 5
) (
  input  logic [RF_AW-1:0] id_rs1,
  input  logic [RF_AW-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [RF_AW-1:0] ex_rd,
  input  logic             ex_mem_read,
  output logic             load_use
);

  logic w_hit_rs1;
  logic w_hit_rs2;

  assign w_hit_rs1 = id_use_rs1 && (id_rs1 == ex_rd);
  assign w_hit_rs2 = id_use_rs2 && (id_rs2 == ex_rd);
  assign load_use  = ex_mem_read && (ex_rd != '0) && (w_hit_rs1 || w_hit_rs2);

endmodule

`default_nettype wire

// File: rtl/pc_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pc_hazard_ctrl : PC redirect / stall and IF/ID, ID/EX hold-flush-bubble control
// Optional build macro HAZARD_PERF_EN adds perf counters.        Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pc_hazard_ctrl
  import pc_hazard_ctrl_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RF_AW    = 5,
  parameter int WAIT_MAX = 255
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [RF_AW-1:0] id_rs1,
  input  logic [RF_AW-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [RF_AW-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_br_taken,
  input  logic [XLEN-1:0]  ex_br_target,
  input  logic             id_jump,
  input  logic [XLEN-1:0]  id_jump_target,
  input  logic             mem_busy,
  input  logic             trap_req,
  input  logic [XLEN-1:0]  trap_vector,
  output logic             stall,
  output logic             if_id_hold,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             pc_sel,
  output logic [XLEN-1:0]  pc_target,
  output logic             timeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]      perf_stall_cycles,
  output logic [31:0]      perf_flush_events,
  output logic [31:0]      perf_timeouts
`endif
);

  localparam int                c_cnt_w    = $clog2(WAIT_MAX + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WAIT_MAX - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(WAIT_MAX);

  state_e              state_q, state_d;
  logic [c_cnt_w-1:0]  cnt_q, cnt_d;
  logic                pend_valid_q, pend_valid_d;
  cause_e              pend_cause_q, pend_cause_d;
  logic [XLEN-1:0]     pend_target_q, pend_target_d;
  logic [XLEN-1:0]     last_target_q, last_target_d;

  logic                w_load_use;
  cause_e              w_req_cause;
  cause_e              w_frz_cause;
  logic [XLEN-1:0]     w_req_target;
  logic [XLEN-1:0]     w_frz_target;
  logic                w_busy_eff;
  logic                w_run_eval;
  logic                w_stall, w_hold, w_bubble, w_if_flush, w_ex_flush, w_pc_sel, w_timeout;
  logic [XLEN-1:0]     w_target;

  pc_hazard_ctrl_hazard_detect #(.RF_AW(RF_AW)) u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (w_load_use)
  );

  // While frozen only EX-resolved redirects are captured; the jump stays in ID.
  assign w_req_cause  = redirect_cause(trap_req, ex_br_taken, id_jump);
  assign w_frz_cause  = redirect_cause(trap_req, ex_br_taken, 1'b0);
  assign w_frz_target = trap_req ? trap_vector : ex_br_target;

  always_comb begin
    case (w_req_cause)
      CAUSE_TRAP:   w_req_target = trap_vector;
      CAUSE_BRANCH: w_req_target = ex_br_target;
      CAUSE_JUMP:   w_req_target = id_jump_target;
      default:      w_req_target = '0;
    endcase
  end

  always_comb begin
    w_stall       = 1'b0;
    w_hold        = 1'b0;
    w_bubble      = 1'b0;
    w_if_flush    = 1'b0;
    w_ex_flush    = 1'b0;
    w_pc_sel      = 1'b0;
    w_timeout     = 1'b0;
    w_target      = last_target_q;
    w_run_eval    = 1'b0;
    w_busy_eff    = mem_busy && (state_q == ST_RUN);
    state_d       = state_q;
    cnt_d         = cnt_q;
    pend_valid_d  = pend_valid_q;
    pend_cause_d  = pend_cause_q;
    pend_target_d = pend_target_q;
    last_target_d = last_target_q;

    case (state_q)
      ST_RUN: w_run_eval = 1'b1;

      ST_MEM_WAIT: begin
        if (!mem_busy) begin
          w_run_eval = 1'b1;
        end else if (cnt_q >= c_cnt_last) begin
          // Limit hit: pulse and treat this cycle as unfrozen.
          w_timeout  = 1'b1;
          w_run_eval = 1'b1;
        end else begin
          w_stall = 1'b1;
          w_hold  = 1'b1;
          cnt_d   = (cnt_q == c_cnt_max) ? cnt_q : cnt_q + c_cnt_w'(1);
          if (w_frz_cause != CAUSE_NONE) begin
            pend_valid_d  = 1'b1;
            pend_cause_d  = w_frz_cause;
            pend_target_d = w_frz_target;
            state_d       = ST_HOLD_REDIR;
            cnt_d         = '0;
          end
        end
      end

      ST_HOLD_REDIR: begin
        if (mem_busy) begin
          w_stall = 1'b1;
          w_hold  = 1'b1;
          if (cause_wins(w_frz_cause, pend_cause_q)) begin
            pend_cause_d  = w_frz_cause;
            pend_target_d = w_frz_target;
          end
        end else begin
          w_pc_sel      = pend_valid_q;
          w_target      = pend_target_q;
          w_if_flush    = 1'b1;
          w_ex_flush    = 1'b1;
          last_target_d = pend_target_q;
          pend_valid_d  = 1'b0;
          pend_cause_d  = CAUSE_NONE;
          state_d       = ST_RUN;
        end
      end

      default: state_d = ST_RUN;
    endcase

    if (w_run_eval) begin
      state_d = ST_RUN;
      cnt_d   = '0;
      if (w_req_cause != CAUSE_NONE) begin
        {w_if_flush, w_ex_flush} = cause_flushes(w_req_cause);
        if (w_busy_eff) begin
          w_stall       = 1'b1;
          pend_valid_d  = 1'b1;
          pend_cause_d  = w_req_cause;
          pend_target_d = w_req_target;
          state_d       = ST_HOLD_REDIR;
        end else begin
          w_pc_sel      = 1'b1;
          w_target      = w_req_target;
          last_target_d = w_req_target;
        end
      end else if (w_busy_eff) begin
        w_stall = 1'b1;
        w_hold  = 1'b1;
        state_d = ST_MEM_WAIT;
        cnt_d   = c_cnt_w'(1);
      end else if (w_load_use) begin
        w_stall  = 1'b1;
        w_hold   = 1'b1;
        w_bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_RUN;
      cnt_q         <= '0;
      pend_valid_q  <= 1'b0;
      pend_cause_q  <= CAUSE_NONE;
      pend_target_q <= '0;
      last_target_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pend_valid_q  <= pend_valid_d;
      pend_cause_q  <= pend_cause_d;
      pend_target_q <= pend_target_d;
      last_target_q <= last_target_d;
    end
  end

  // Outputs are forced quiet for as long as reset is held.
  assign stall        = reset_n & w_stall;
  assign if_id_hold   = reset_n & w_hold;
  assign id_ex_bubble = reset_n & w_bubble;
  assign if_id_flush  = reset_n & w_if_flush;
  assign id_ex_flush  = reset_n & w_ex_flush;
  assign pc_sel       = reset_n & w_pc_sel;
  assign timeout      = reset_n & w_timeout;
  assign pc_target    = {XLEN{reset_n}} & w_target;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;
  logic [31:0] perf_tmo_q,   perf_tmo_d;

  always_comb begin
    perf_stall_d = perf_stall_q + {31'd0, stall};
    perf_flush_d = perf_flush_q + {31'd0, (if_id_flush | id_ex_flush)};
    perf_tmo_d   = perf_tmo_q + {31'd0, timeout};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
      perf_tmo_q   <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
      perf_tmo_q   <= perf_tmo_d;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flush_events = perf_flush_q;
  assign perf_timeouts     = perf_tmo_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_hazard_ctrl : vector table + scoreboard bench for pc_hazard_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pc_hazard_ctrl;

  localparam int XLEN = 32;
  localparam int RF_AW = 5;

  // flag order: {stall, if_id_hold, id_ex_bubble, if_id_flush, id_ex_flush, pc_sel, timeout}
  localparam logic [6:0] F_0     = 7'b0000000;
  localparam logic [6:0] F_LU    = 7'b1110000;
  localparam logic [6:0] F_BR    = 7'b0001110;
  localparam logic [6:0] F_JMP   = 7'b0001010;
  localparam logic [6:0] F_BUSY  = 7'b1100000;
  localparam logic [6:0] F_CAPBR = 7'b1001100;
  localparam logic [6:0] F_CAPJ  = 7'b1001000;
  localparam logic [6:0] F_TMO   = 7'b0000001;

  typedef struct {
    string            name;
    logic [RF_AW-1:0] rs1, rs2, rd;
    logic             u1, u2, mr, br, jmp, busy, trap;
    logic [XLEN-1:0]  brt, jt, tv;
    logic [6:0]       f;
    logic [XLEN-1:0]  t;
  } vec_t;

  logic             clock = 1'b0;
  logic             reset_n;
  logic [RF_AW-1:0] id_rs1, id_rs2, ex_rd;
  logic             id_use_rs1, id_use_rs2, ex_mem_read, ex_br_taken, id_jump, mem_busy, trap_req;
  logic [XLEN-1:0]  ex_br_target, id_jump_target, trap_vector;
  logic             stall, if_id_hold, id_ex_bubble, if_id_flush, id_ex_flush, pc_sel, timeout;
  logic [XLEN-1:0]  pc_target;

  int   n_vec = 0;
  int   n_bad = 0;
  vec_t sb[$];
  vec_t tbl[$];

  always #5 clock = ~clock;

  pc_hazard_ctrl #(.XLEN(XLEN), .RF_AW(RF_AW), .WAIT_MAX(4)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .ex_rd          (ex_rd),
    .ex_mem_read    (ex_mem_read),
    .ex_br_taken    (ex_br_taken),
    .ex_br_target   (ex_br_target),
    .id_jump        (id_jump),
    .id_jump_target (id_jump_target),
    .mem_busy       (mem_busy),
    .trap_req       (trap_req),
    .trap_vector    (trap_vector),
    .stall          (stall),
    .if_id_hold     (if_id_hold),
    .id_ex_bubble   (id_ex_bubble),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .pc_sel         (pc_sel),
    .pc_target      (pc_target),
    .timeout        (timeout)
  );

  function automatic vec_t V(input string n,
                             input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                             input logic [4:0] rd, input logic mr,
                             input logic br, input logic [31:0] brt, input logic jmp, input logic [31:0] jt,
                             input logic busy, input logic trap, input logic [31:0] tv,
                             input logic [6:0] f, input logic [31:0] t);
    vec_t v;
    v.name = n; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.rd = rd; v.mr = mr;
    v.br = br; v.brt = brt; v.jmp = jmp; v.jt = jt; v.busy = busy; v.trap = trap; v.tv = tv;
    v.f = f; v.t = t;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    id_rs1 = v.rs1; id_use_rs1 = v.u1; id_rs2 = v.rs2; id_use_rs2 = v.u2;
    ex_rd = v.rd; ex_mem_read = v.mr; ex_br_taken = v.br; ex_br_target = v.brt;
    id_jump = v.jmp; id_jump_target = v.jt; mem_busy = v.busy; trap_req = v.trap; trap_vector = v.tv;
    sb.push_back(v);
  endtask

  task automatic check_out();
    vec_t       e;
    logic [6:0] got;
    n_vec++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard: no expected entry queued");
    end else begin
      e   = sb.pop_front();
      got = {stall, if_id_hold, id_ex_bubble, if_id_flush, id_ex_flush, pc_sel, timeout};
      if (got !== e.f || pc_target !== e.t) begin
        n_bad++;
        $display("FAIL %s: flags got %b want %b, pc_target got %h want %h", e.name, got, e.f, pc_target, e.t);
      end
    end
  endtask

  // Drive just after posedge, compare at negedge.
  task automatic apply(input vec_t v);
    drive(v);
    @(negedge clock);
    check_out();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    drive(V("reset", 5'd5, 1, 5'd0, 0, 5'd5, 1, 1, 32'h40, 1, 32'h80, 1, 1, 32'h8, F_0, 32'h0));
    #12;
    check_out();
    drive(V("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, F_0, 32'h0));
    void'(sb.pop_back());
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    //         name          rs1 u1 rs2 u2 rd mr br brt      jmp jt      busy trap tv     flags    target
    tbl.push_back(V("idle0",     0, 0, 0, 0, 0, 0, 0, 0,       0, 0,       0, 0, 0,       F_0,     32'h0));
    tbl.push_back(V("lu_rs1",    5, 1, 0, 0, 5, 1, 0, 0,       0, 0,       0, 0, 0,       F_LU,    32'h0));
    tbl.push_back(V("lu_rd0",    0, 1, 0, 0, 0, 1, 0, 0,       0, 0,       0, 0, 0,       F_0,     32'h0));
    tbl.push_back(V("lu_rs2",    3, 1, 7, 1, 7, 1, 0, 0,       0, 0,       0, 0, 0,       F_LU,    32'h0));
    tbl.push_back(V("lu_nouse",  5, 0, 5, 0, 5, 1, 0, 0,       0, 0,       0, 0, 0,       F_0,     32'h0));
    tbl.push_back(V("lu_noload", 5, 1, 0, 0, 5, 0, 0, 0,       0, 0,       0, 0, 0,       F_0,     32'h0));
    tbl.push_back(V("br_jmp",    0, 0, 0, 0, 0, 0, 1, 32'h40,  1, 32'h80,  0, 0, 0,       F_BR,    32'h40));
    tbl.push_back(V("hold_tgt",  0, 0, 0, 0, 0, 0, 0, 0,       0, 0,       0, 0, 0,       F_0,     32'h40));
    tbl.push_back(V("jump",      0, 0, 0, 0, 0, 0, 0, 0,       1, 32'h80,  0, 0, 0,       F_JMP,   32'h80));
    tbl.push_back(V("trap_lu",   5, 1, 0, 0, 5, 1, 1, 32'h40,  0, 0,       0, 1, 32'h8,   F_BR,    32'h8));
    tbl.push_back(V("jump_lu",   5, 1, 0, 0, 5, 1, 0, 0,       1, 32'h80,  0, 0, 0,       F_JMP,   32'h80));
    tbl.push_back(V("busy1",     0, 0, 0, 0, 0, 0, 0, 0,       0, 0,       1, 0, 0,       F_BUSY,  32'h80));
    tbl.push_back(V("busy2_br",  0, 0, 0, 0, 0, 0, 1, 32'h100, 0, 0,       1, 0, 0,       F_BUSY,  32'h80));
    tbl.push_back(V("busy3",     0, 0, 0, 0, 0, 0, 0, 0,       0, 0,       1, 0, 0,       F_BUSY,  32'h80));
    tbl.push_back(V("rel_br",    0, 0, 0, 0, 0, 0, 0, 0,       0, 0,       0, 0, 0,       F_BR,    32'h100));
    tbl.push_back(V("run_lu",    5, 1, 0, 0, 5, 1, 0, 0,       0, 0,       0, 0, 0,       F_LU,    32'h100));
    tbl.push_back(V("cap_br",    0, 0, 0, 0, 0, 0, 1, 32'h200, 0, 0,       1, 0, 0,       F_CAPBR, 32'h100));
    tbl.push_back(V("ovr_trap",  0, 0, 0, 0, 0, 0, 0, 0,       0, 0,       1, 1, 32'h8,   F_BUSY,  32'h100));
    tbl.push_back(V("br_no_ovr", 0, 0, 0, 0, 0, 0, 1, 32'h300, 0, 0,       1, 0, 0,       F_BUSY,  32'h100));
    tbl.push_back(V("rel_trap",  0, 0, 0, 0, 0, 0, 0, 0,       0, 0,       0, 0, 0,       F_BR,    32'h8));
    tbl.push_back(V("busy_a",    0, 0, 0, 0, 0, 0, 0, 0,       0, 0,       1, 0, 0,       F_BUSY,  32'h8));
    tbl.push_back(V("exit_jmp",  0, 0, 0, 0, 0, 0, 0, 0,       1, 32'h44,  0, 0, 0,       F_JMP,   32'h44));
    tbl.push_back(V("idle1",     0, 0, 0, 0, 0, 0, 0, 0,       0, 0,       0, 0, 0,       F_0,     32'h44));
    tbl.push_back(V("cap_jmp",   0, 0, 0, 0, 0, 0, 0, 0,       1, 32'h50,  1, 0, 0,       F_CAPJ,  32'h44));
    tbl.push_back(V("rel_jmp",   0, 0, 0, 0, 0, 0, 0, 0,       0, 0,       0, 0, 0,       F_BR,    32'h50));

    foreach (tbl[i]) apply(tbl[i]);

    // Stuck mem_busy with WAIT_MAX=4: pulse on the 4th busy cycle, then a fresh count.
    for (int i = 0; i < 8; i++) begin
      apply(V("tmo", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,
              ((i == 3) || (i == 7)) ? F_TMO : F_BUSY, 32'h50));
    end
    apply(V("tmo_done", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, F_0, 32'h50));

    // Reset while a redirect is pending must drop it.
    apply(V("rst_cap",  0, 0, 0, 0, 0, 0, 1, 32'h100, 0, 0, 1, 0, 0, F_CAPBR, 32'h50));
    apply(V("rst_hold", 0, 0, 0, 0, 0, 0, 0, 0,       0, 0, 1, 0, 0, F_BUSY,  32'h50));
    drive(V("rst_async", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, F_0, 32'h0));
    reset_n = 1'b0;
    #2;
    check_out();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    apply(V("rst_rel0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, F_0, 32'h0));
    apply(V("rst_rel1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, F_0, 32'h0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
